// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response and tohost handshake bundle between the core and the data-memory responder.
interface dmem_responder_if #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 32
);
    logic                req_valid;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [ADDR_LEN-1:0] req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                rsp_valid;
    logic [XLEN-1:0]     rsp_data;
    logic                rsp_err;
    logic                tohost_valid;
    logic [XLEN-1:0]     tohost_data;
    logic                tohost_ready;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, tohost_ready,
        input  rsp_valid, rsp_data, rsp_err, tohost_valid, tohost_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, tohost_ready,
        output rsp_valid, rsp_data, rsp_err, tohost_valid, tohost_data
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM with byte-lane stores and extended sub-word loads, plus an MMIO
// window holding a free-running cycle counter and a tohost FIFO; responses one cycle after request.
module dmem_responder #(
    parameter int                  XLEN        = 32,
    parameter int                  ADDR_LEN    = 32,
    parameter int                  DEPTH_WORDS = 1024,
    parameter int                  FIFO_DEPTH  = 4,
    parameter logic [ADDR_LEN-1:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0] r_mem  [DEPTH_WORDS];
    logic [XLEN-1:0] r_fifo [FIFO_DEPTH];
    logic [FW-1:0]   r_rd, r_wr;
    logic [FW:0]     r_cnt;
    logic [XLEN-1:0] r_cycle;
    logic            r_ovf;
    logic            r_rsp_valid, r_rsp_err;
    logic [XLEN-1:0] r_rsp_data;

    logic [1:0]      w_sz, w_a;
    logic [15:0]     w_off;
    logic            w_mmio, w_err, w_ld, w_st, w_full, w_empty;
    logic            w_pop, w_push_req, w_push, w_clr, w_ram_we;
    logic [XLEN-1:0] w_word, w_sh, w_ram_ld, w_mmio_ld, w_wd;
    logic [3:0]      w_be;

    assign w_sz   = bus.req_size;
    assign w_a    = bus.req_addr[1:0];
    assign w_off  = bus.req_addr[15:0];
    assign w_mmio = bus.req_addr >= MMIO_BASE;
    assign w_err  = (w_sz == 2'b11) || (w_sz == 2'b01 && w_a[0]) || (w_sz == 2'b10 && w_a != 2'b00) ||
                    (w_mmio && (w_sz != 2'b10 || !(w_off == 16'h0 || w_off == 16'h4 || w_off == 16'h8)));
    assign w_ld   = bus.req_valid && !bus.req_we && !w_err;
    assign w_st   = bus.req_valid && bus.req_we && !w_err;

    // Half loads are aligned here, so the byte-lane shift also lands the half on bit 0.
    assign w_word   = r_mem[bus.req_addr[AW+1:2]];
    assign w_sh     = w_word >> {w_a, 3'b000};
    assign w_ram_ld = (w_sz == 2'b00) ? {{24{!bus.req_unsigned && w_sh[7]}}, w_sh[7:0]} :
                      (w_sz == 2'b01) ? {{16{!bus.req_unsigned && w_sh[15]}}, w_sh[15:0]} : w_word;

    assign w_full    = r_cnt == (FW+1)'(FIFO_DEPTH);
    assign w_empty   = r_cnt == '0;
    assign w_mmio_ld = (w_off == 16'h0) ? r_cycle :
                       (w_off == 16'h4) ? {{(XLEN-FW-1){1'b0}}, r_cnt} :
                       {{(XLEN-3){1'b0}}, r_ovf, w_empty, w_full};

    // A pop frees the slot in the same cycle, so a push into a full FIFO is still taken.
    assign w_pop      = !w_empty && bus.tohost_ready;
    assign w_push_req = w_st && w_mmio && w_off == 16'h4;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_clr      = w_st && w_mmio && w_off == 16'h8;
    assign w_ram_we   = w_st && !w_mmio;

    assign w_be = (w_sz == 2'b00) ? 4'b0001 << w_a : (w_sz == 2'b01) ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd = (w_sz == 2'b00) ? {4{bus.req_wdata[7:0]}} :
                  (w_sz == 2'b01) ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_cycle     <= r_cycle + 1;
            r_rsp_valid <= bus.req_valid;
            r_rsp_err   <= bus.req_valid && w_err;
            r_rsp_data  <= w_ld ? (w_mmio ? w_mmio_ld : w_ram_ld) : '0;
            r_rd        <= w_pop ? r_rd + FW'(1) : r_rd;
            r_wr        <= w_push ? r_wr + FW'(1) : r_wr;
            r_cnt       <= r_cnt + (FW+1)'(w_push) - (FW+1)'(w_pop);
            r_ovf       <= w_clr ? 1'b0 : (w_push_req && !w_push) ? 1'b1 : r_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr] <= bus.req_wdata;
        for (int i = 0; i < 4; i++)
            if (w_ram_we && w_be[i])
                r_mem[bus.req_addr[AW+1:2]][8*i +: 8] <= w_wd[8*i +: 8];
    end

    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.tohost_valid = !w_empty;
    assign bus.tohost_data  = w_empty ? '0 : r_fifo[r_rd];
endmodule
